// File: rtl/pic_pkg.sv
// Shared constants and state type for the intr_pic interrupt controller.
package pic_pkg;

    localparam logic [1:0] PIC_MASK = 2'd0;
    localparam logic [1:0] PIC_PEND = 2'd1;
    localparam logic [1:0] PIC_STAT = 2'd2;
    localparam logic [1:0] PIC_EOI  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2
    } pic_state_t;

endpackage

// File: rtl/pic_prio_enc.sv
// Priority encoder: first set bit of i_eligible searched circularly from i_start.
module pic_prio_enc #(
    parameter int NSRC = 8,
    parameter int VW   = 3
) (
    input  logic [NSRC-1:0] i_eligible,
    input  logic [VW-1:0]   i_start,
    output logic            o_valid,
    output logic [VW-1:0]   o_index
);

    int w_pos;

    // Scan from the far end back toward i_start so the nearest candidate is assigned last.
    always_comb begin
        o_valid = |i_eligible;
        o_index = '0;
        w_pos   = 0;
        for (int k = NSRC - 1; k >= 0; k--) begin
            w_pos = (int'(i_start) + k) % NSRC;
            if (i_eligible[w_pos]) begin
                o_index = VW'(w_pos);
            end
        end
    end

endmodule

// File: rtl/intr_pic.sv
// intr_pic: edge-latched, maskable interrupt controller with request/service handshake.
// Define PIC_ROTATE_PRI_EN for rotating priority; otherwise index 0 is always highest.
//
//   state | meaning
//   IDLE  | no request outstanding, watching eligible sources
//   REQ   | intr raised for vector, waiting for inta
//   SVC   | vector in service, waiting for EOI write
module intr_pic
    import pic_pkg::*;
#(
    parameter int NSRC = 8,
    parameter int VW   = 3
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic [NSRC-1:0] irq,
    output logic            intr,
    input  logic            inta,
    output logic [VW-1:0]   vector,
    output logic            busy,
    input  logic            we,
    input  logic [1:0]      addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata
);

    pic_state_t      r_state;
    pic_state_t      w_state_nxt;
    logic [NSRC-1:0] r_mask;
    logic [NSRC-1:0] r_pend;
    logic [NSRC-1:0] r_irq_d;
    logic [VW-1:0]   r_vector;

    logic [NSRC-1:0] w_edge;
    logic [NSRC-1:0] w_eligible;
    logic [NSRC-1:0] w_clr;
    logic [NSRC-1:0] w_pend_nxt;
    logic [NSRC-1:0] w_mask_nxt;
    logic [NSRC-1:0] w_vec_onehot;
    logic            w_wr_mask;
    logic            w_wr_pend;
    logic            w_wr_eoi;
    logic            w_grant;
    logic            w_keep;
    logic            w_win_valid;
    logic [VW-1:0]   w_win_idx;
    logic [VW-1:0]   w_start;

    assign w_wr_mask    = we && (addr == PIC_MASK);
    assign w_wr_pend    = we && (addr == PIC_PEND);
    assign w_wr_eoi     = we && (addr == PIC_EOI);
    assign w_grant      = (r_state == REQ) && inta;
    assign w_edge       = irq & ~r_irq_d;
    assign w_eligible   = r_pend & ~r_mask;
    assign w_vec_onehot = {{(NSRC-1){1'b0}}, 1'b1} << r_vector;

    // A new edge always wins over a W1C or grant clear in the same cycle.
    assign w_clr      = (w_wr_pend ? wdata[NSRC-1:0] : '0) | (w_grant ? w_vec_onehot : '0);
    assign w_pend_nxt = (r_pend & ~w_clr) | w_edge;
    assign w_mask_nxt = w_wr_mask ? wdata[NSRC-1:0] : r_mask;
    assign w_keep     = w_pend_nxt[r_vector] & ~w_mask_nxt[r_vector];

    generate
        if (NSRC < 32) begin : g_unused
            logic w_unused;
            assign w_unused = &{1'b0, wdata[31:NSRC]};
        end
    endgenerate

`ifdef PIC_ROTATE_PRI_EN
    logic [VW-1:0] r_last;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_last <= '0;
        end else if (w_grant) begin
            r_last <= r_vector;
        end
    end

    assign w_start = (r_last == VW'(NSRC - 1)) ? '0 : r_last + VW'(1);
`else
    assign w_start = '0;
`endif

    pic_prio_enc #(
        .NSRC (NSRC),
        .VW   (VW)
    ) u_prio_enc (
        .i_eligible (w_eligible),
        .i_start    (w_start),
        .o_valid    (w_win_valid),
        .o_index    (w_win_idx)
    );

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state  <= IDLE;
            r_mask   <= '1;
            r_pend   <= '0;
            r_irq_d  <= '0;
            r_vector <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_mask   <= w_mask_nxt;
            r_pend   <= w_pend_nxt;
            r_irq_d  <= irq;
            if ((r_state == IDLE) && w_win_valid) begin
                r_vector <= w_win_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_win_valid) w_state_nxt = REQ;
            REQ: begin
                if (w_grant) begin
                    w_state_nxt = SVC;
                end else if (!w_keep) begin
                    w_state_nxt = IDLE;
                end
            end
            SVC:     if (w_wr_eoi) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        intr   = (r_state == REQ);
        busy   = (r_state == SVC);
        vector = r_vector;
    end

    always_comb begin
        rdata = '0;
        case (addr)
            PIC_MASK: rdata = 32'(r_mask);
            PIC_PEND: rdata = 32'(r_pend);
            PIC_STAT: rdata = 32'({busy, r_vector});
            default:  rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_intr_pic.sv
// Directed table-driven bench for intr_pic plus rotation and reset sequences.
module tb_intr_pic;

    logic        clk;
    logic        clrn;
    logic [7:0]  irq;
    logic        intr;
    logic        inta;
    logic [2:0]  vector;
    logic        busy;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    int checks   = 0;
    int failures = 0;

    intr_pic #(.NSRC(8), .VW(3)) dut (
        .clk    (clk),
        .clrn   (clrn),
        .irq    (irq),
        .intr   (intr),
        .inta   (inta),
        .vector (vector),
        .busy   (busy),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [7:0]  irq;
        logic        inta;
        logic        e_intr;
        logic [2:0]  e_vec;
        logic        e_busy;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic w, logic [1:0] a, logic [31:0] d, logic [7:0] rq,
                               logic ak, logic ei, logic [2:0] ev, logic eb, logic [31:0] er);
        vec_t r;
        r.we = w; r.addr = a; r.wdata = d; r.irq = rq; r.inta = ak;
        r.e_intr = ei; r.e_vec = ev; r.e_busy = eb; r.e_rdata = er;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(logic w, logic [1:0] a, logic [31:0] d, logic [7:0] rq, logic ak);
        we = w; addr = a; wdata = d; irq = rq; inta = ak;
    endtask

    task automatic cyc(logic w, logic [1:0] a, logic [31:0] d, logic [7:0] rq, logic ak);
        drive(w, a, d, rq, ak);
        @(posedge clk);
        #1;
    endtask

    int exp_grant[4];
    bit got;

    initial begin
        clrn = 1'b0;
        drive(0, 2'd0, 0, 8'h00, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_intr", intr, 0);
        chk("reset_busy", busy, 0);
        chk("reset_vector", vector, 0);
        chk("reset_mask", rdata, 32'hFF);
        clrn = 1'b1;

        //            we addr wdata  irq  ak | intr vec busy rdata
        tbl.push_back(v(1, 0, 32'hFE, 8'h00, 0, 0, 0, 0, 32'hFF));
        tbl.push_back(v(0, 1, 32'h00, 8'h01, 0, 0, 0, 0, 32'h00));
        tbl.push_back(v(0, 1, 32'h00, 8'h00, 0, 0, 0, 0, 32'h01));
        tbl.push_back(v(0, 1, 32'h00, 8'h00, 0, 1, 0, 0, 32'h01));
        tbl.push_back(v(0, 2, 32'h00, 8'h00, 1, 1, 0, 0, 32'h00));
        tbl.push_back(v(0, 1, 32'h00, 8'h00, 0, 0, 0, 1, 32'h00));
        tbl.push_back(v(0, 2, 32'h00, 8'h00, 0, 0, 0, 1, 32'h08));
        tbl.push_back(v(1, 3, 32'h00, 8'h00, 0, 0, 0, 1, 32'h00));
        tbl.push_back(v(0, 2, 32'h00, 8'h00, 0, 0, 0, 0, 32'h00));
        tbl.push_back(v(1, 0, 32'h00, 8'h00, 0, 0, 0, 0, 32'hFE));
        tbl.push_back(v(0, 1, 32'h00, 8'h24, 0, 0, 0, 0, 32'h00));
        tbl.push_back(v(0, 1, 32'h00, 8'h00, 0, 0, 0, 0, 32'h24));
        tbl.push_back(v(0, 2, 32'h00, 8'h00, 0, 1, 2, 0, 32'h02));
        tbl.push_back(v(0, 2, 32'h00, 8'h00, 1, 1, 2, 0, 32'h02));
        tbl.push_back(v(0, 1, 32'h00, 8'h00, 0, 0, 2, 1, 32'h20));
        tbl.push_back(v(1, 3, 32'h00, 8'h00, 0, 0, 2, 1, 32'h00));
        tbl.push_back(v(0, 2, 32'h00, 8'h00, 0, 0, 2, 0, 32'h02));
        tbl.push_back(v(0, 2, 32'h00, 8'h00, 0, 1, 5, 0, 32'h05));
        tbl.push_back(v(0, 1, 32'h00, 8'h00, 1, 1, 5, 0, 32'h20));
        tbl.push_back(v(1, 3, 32'h00, 8'h00, 0, 0, 5, 1, 32'h00));
        tbl.push_back(v(0, 1, 32'h00, 8'h00, 0, 0, 5, 0, 32'h00));
        tbl.push_back(v(0, 1, 32'h00, 8'h08, 0, 0, 5, 0, 32'h00));
        tbl.push_back(v(0, 1, 32'h00, 8'h00, 0, 0, 5, 0, 32'h08));
        tbl.push_back(v(1, 0, 32'h08, 8'h00, 0, 1, 3, 0, 32'h00));
        tbl.push_back(v(0, 1, 32'h00, 8'h00, 0, 0, 3, 0, 32'h08));
        tbl.push_back(v(0, 1, 32'h00, 8'h00, 0, 0, 3, 0, 32'h08));
        tbl.push_back(v(1, 0, 32'h00, 8'h00, 0, 0, 3, 0, 32'h08));
        tbl.push_back(v(0, 1, 32'h00, 8'h00, 0, 0, 3, 0, 32'h08));
        tbl.push_back(v(0, 2, 32'h00, 8'h00, 0, 1, 3, 0, 32'h03));
        tbl.push_back(v(0, 1, 32'h00, 8'h00, 1, 1, 3, 0, 32'h08));
        tbl.push_back(v(1, 3, 32'h00, 8'h00, 0, 0, 3, 1, 32'h00));
        tbl.push_back(v(0, 2, 32'h00, 8'h00, 0, 0, 3, 0, 32'h03));
        tbl.push_back(v(1, 0, 32'h02, 8'h00, 0, 0, 3, 0, 32'h00));
        tbl.push_back(v(0, 1, 32'h00, 8'h02, 0, 0, 3, 0, 32'h00));
        tbl.push_back(v(0, 1, 32'h00, 8'h00, 0, 0, 3, 0, 32'h02));
        tbl.push_back(v(1, 1, 32'h02, 8'h02, 0, 0, 3, 0, 32'h02));
        tbl.push_back(v(0, 1, 32'h00, 8'h00, 0, 0, 3, 0, 32'h02));
        tbl.push_back(v(1, 1, 32'h02, 8'h00, 0, 0, 3, 0, 32'h02));
        tbl.push_back(v(0, 1, 32'h00, 8'h00, 0, 0, 3, 0, 32'h00));
        tbl.push_back(v(0, 2, 32'h00, 8'h00, 1, 0, 3, 0, 32'h03));
        tbl.push_back(v(0, 2, 32'h00, 8'h00, 0, 0, 3, 0, 32'h03));
        tbl.push_back(v(1, 3, 32'h00, 8'h00, 0, 0, 3, 0, 32'h00));
        tbl.push_back(v(0, 2, 32'h00, 8'h00, 0, 0, 3, 0, 32'h03));

        foreach (tbl[i]) begin
            drive(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].irq, tbl[i].inta);
            #3;
            chk($sformatf("t%0d_intr", i), intr, tbl[i].e_intr);
            chk($sformatf("t%0d_vector", i), vector, tbl[i].e_vec);
            chk($sformatf("t%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("t%0d_rdata", i), rdata, tbl[i].e_rdata);
            @(posedge clk);
            #1;
        end

`ifdef PIC_ROTATE_PRI_EN
        exp_grant = '{0, 1, 0, 1};
`else
        exp_grant = '{0, 0, 0, 0};
`endif
        // irq[0] and irq[1] retriggered together on each EOI cycle
        cyc(1, 2'd0, 32'h00, 8'h00, 0);
        cyc(0, 2'd2, 32'h00, 8'h03, 0);
        for (int r = 0; r < 4; r++) begin
            got = 0;
            for (int w = 0; w < 10 && !got; w++) begin
                #3;
                if (intr) got = 1;
                else begin
                    @(posedge clk);
                    #1;
                end
            end
            if (!got) begin
                checks++;
                failures++;
                $display("FAIL rot%0d_timeout actual=intr_low required=intr_high", r);
            end
            chk($sformatf("rot%0d_grant", r), vector, exp_grant[r]);
            @(posedge clk);
            #1;
            cyc(0, 2'd2, 32'h00, 8'h03, 1);
            chk($sformatf("rot%0d_busy", r), busy, 1);
            cyc(0, 2'd2, 32'h00, 8'h00, 0);
            cyc(1, 2'd3, 32'h00, 8'h03, 0);
        end

        // reach SVC, then reset mid-service
        repeat (3) cyc(0, 2'd2, 32'h00, 8'h03, 0);
        chk("pre_rst_intr", intr, 1);
        cyc(0, 2'd2, 32'h00, 8'h03, 1);
        chk("pre_rst_busy", busy, 1);
        clrn = 1'b0;
        drive(0, 2'd1, 32'h00, 8'h00, 0);
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_intr", intr, 0);
        chk("midrst_vector", vector, 0);
        chk("midrst_pend", rdata, 32'h00);
        addr = 2'd0;
        #1;
        chk("midrst_mask", rdata, 32'hFF);
        @(posedge clk);
        #1;
        clrn = 1'b1;
        cyc(0, 2'd1, 32'h00, 8'h00, 0);
        cyc(0, 2'd1, 32'h00, 8'h00, 0);
        chk("post_rst_intr", intr, 0);
        chk("post_rst_pend", rdata, 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
